// File: rtl/blink_rate_pkg.sv
`default_nettype none
// ============================================================================
// Module      : blink_rate_pkg
// Description : Shared constants for the blink/clock generator. Holds the
//               default 1 MHz board timing presets and the helper that sizes
//               the mode index.
// Revision    : 1.0 - initial release
// ============================================================================
package blink_rate_pkg;

    localparam int DEF_CNT_W   = 22;
    localparam int DEF_N_MODES = 3;

    // Entry m sits in bits [m*CNT_W +: CNT_W]; mode 0 is the rightmost entry.
    localparam logic [DEF_N_MODES*DEF_CNT_W-1:0] DEF_LOW_DUR =
        {22'h06acfc, 22'h0d59f8, 22'h1406f4};
    localparam logic [DEF_N_MODES*DEF_CNT_W-1:0] DEF_HIGH_DUR =
        {22'h0d59f8, 22'h1ab3f0, 22'h280de8};

    // Width of the mode index; never less than one bit.
    function automatic int mode_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage : blink_rate_pkg
`default_nettype wire

// File: rtl/rate_counter.sv
`default_nettype none
// ============================================================================
// Module      : rate_counter
// Description : Phase duration counter with synchronous clear, count enable
//               and terminal-count compare against the selected duration.
// Ports       : clk   - system clock
//               reset - synchronous active-high reset
//               clr   - synchronous clear (wins over enable)
//               en    - count enable; when low the count is frozen
//               dur   - current phase length in cycles (must be >= 1)
//               tc    - high while the count equals dur-1
// Revision    : 1.0 - initial release
// ============================================================================
module rate_counter #(
    parameter int CNT_W = 22
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] dur,
    output logic             tc
);

    logic [CNT_W-1:0] r_count;

    assign tc = (r_count == (dur - CNT_W'(1)));

    // The count only ever returns to zero through the compare, so it cannot
    // run past dur-1 and never relies on natural overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (en) begin
            if (tc) begin
                r_count <= '0;
            end else begin
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

endmodule : rate_counter
`default_nettype wire

// File: rtl/blink_rate_gen.sv
`default_nettype none
// ============================================================================
// Module      : blink_rate_gen
// Description : Asymmetric blink/clock generator. clk_out is held low for
//               LOW_DUR[mode] and high for HIGH_DUR[mode] cycles. Button
//               rising edges step the speed preset up/down with wrap-around;
//               hold freezes the waveform.
// Ports       : clk        - system clock
//               reset      - synchronous active-high reset
//               speed_up   - button level, rising edge steps mode +1
//               speed_down - button level, rising edge steps mode -1
//               hold       - freeze counter and clk_out
//               clk_out    - generated waveform (registered)
//               mode       - current speed preset (registered)
//               phase_done - one-cycle pulse with each clk_out toggle
// Revision    : 1.0 - initial release
// ============================================================================
module blink_rate_gen
    import blink_rate_pkg::*;
#(
    parameter int                         CNT_W    = DEF_CNT_W,
    parameter int                         N_MODES  = DEF_N_MODES,
    parameter logic [N_MODES*CNT_W-1:0]   LOW_DUR  = DEF_LOW_DUR,
    parameter logic [N_MODES*CNT_W-1:0]   HIGH_DUR = DEF_HIGH_DUR,
    localparam int                        MODE_W   = mode_width(N_MODES)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              speed_up,
    input  logic              speed_down,
    input  logic              hold,
    output logic              clk_out,
    output logic [MODE_W-1:0] mode,
    output logic              phase_done
);

    localparam logic [MODE_W-1:0] C_LAST_MODE = MODE_W'(N_MODES - 1);

    logic             r_up_d;
    logic             r_dn_d;
    logic             r_up_ev;
    logic             r_dn_ev;
    logic             w_step_up;
    logic             w_step_dn;
    logic             w_step;
    logic             w_en;
    logic             w_tc;
    logic [CNT_W-1:0] w_raw_dur;
    logic [CNT_W-1:0] w_dur;

    // Edge detectors. During reset the history loads the live level so a
    // button already held when reset releases is not seen as a new press.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_up_d  <= speed_up;
            r_dn_d  <= speed_down;
            r_up_ev <= 1'b0;
            r_dn_ev <= 1'b0;
        end else begin
            r_up_d  <= speed_up;
            r_dn_d  <= speed_down;
            r_up_ev <= speed_up & ~r_up_d;
            r_dn_ev <= speed_down & ~r_dn_d;
        end
    end

    // Simultaneous up and down presses cancel out.
    assign w_step_up = r_up_ev & ~r_dn_ev;
    assign w_step_dn = r_dn_ev & ~r_up_ev;
    assign w_step    = w_step_up | w_step_dn;
    assign w_en      = ~hold;

    always_ff @(posedge clk) begin
        if (reset) begin
            mode <= '0;
        end else if (w_step_up) begin
            mode <= (mode == C_LAST_MODE) ? '0 : mode + MODE_W'(1);
        end else if (w_step_dn) begin
            mode <= (mode == '0) ? C_LAST_MODE : mode - MODE_W'(1);
        end
    end

    // Duration mux. Unused index codes (mode >= N_MODES) never occur but
    // fall back to zero, which the clamp below turns into one cycle.
    always_comb begin
        w_raw_dur = '0;
        for (int i = 0; i < N_MODES; i++) begin
            if (mode == MODE_W'(i)) begin
                w_raw_dur = clk_out ? HIGH_DUR[i*CNT_W +: CNT_W]
                                    : LOW_DUR[i*CNT_W +: CNT_W];
            end
        end
        w_dur = (w_raw_dur == '0) ? CNT_W'(1) : w_raw_dur;
    end

    // A mode step restarts the current phase at count 0, so it also clears
    // the counter even while hold is asserted.
    rate_counter #(
        .CNT_W (CNT_W)
    ) u_rate_counter (
        .clk   (clk),
        .reset (reset),
        .clr   (w_step),
        .en    (w_en),
        .dur   (w_dur),
        .tc    (w_tc)
    );

    // A step in the terminal-count cycle suppresses the toggle: the level is
    // kept and the new duration is counted from zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_out    <= 1'b0;
            phase_done <= 1'b0;
        end else if (w_step) begin
            phase_done <= 1'b0;
        end else if (w_en && w_tc) begin
            clk_out    <= ~clk_out;
            phase_done <= 1'b1;
        end else begin
            phase_done <= 1'b0;
        end
    end

endmodule : blink_rate_gen
`default_nettype wire

// File: tb/tb_blink_rate_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_blink_rate_gen
// Description : Directed bench for blink_rate_gen with CNT_W=4, N_MODES=3,
//               LOW={3,2,1}, HIGH={6,4,2}. A second instance has a zero
//               LOW entry for mode 0.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_blink_rate_gen;

    logic       clk = 1'b0;
    logic       reset;
    logic       speed_up;
    logic       speed_down;
    logic       hold;
    logic       clk_out;
    logic [1:0] mode;
    logic       phase_done;

    logic       tie0 = 1'b0;
    logic       clk_out2;
    logic [1:0] mode2;
    logic       phase_done2;

    int checks   = 0;
    int failures = 0;
    int spurious = 0;

    always #5 clk = ~clk;

    blink_rate_gen #(
        .CNT_W    (4),
        .N_MODES  (3),
        .LOW_DUR  ({4'd1, 4'd2, 4'd3}),
        .HIGH_DUR ({4'd2, 4'd4, 4'd6})
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .speed_up   (speed_up),
        .speed_down (speed_down),
        .hold       (hold),
        .clk_out    (clk_out),
        .mode       (mode),
        .phase_done (phase_done)
    );

    blink_rate_gen #(
        .CNT_W    (4),
        .N_MODES  (3),
        .LOW_DUR  ({4'd1, 4'd2, 4'd0}),
        .HIGH_DUR ({4'd2, 4'd4, 4'd6})
    ) dut_zero (
        .clk        (clk),
        .reset      (reset),
        .speed_up   (tie0),
        .speed_down (tie0),
        .hold       (tie0),
        .clk_out    (clk_out2),
        .mode       (mode2),
        .phase_done (phase_done2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Called at a negedge; counts cycles until clk_out leaves its level.
    task automatic measure(input string tag, input logic exp_lvl, input int exp_n);
        int   n;
        logic lv;
        lv = clk_out;
        n  = 0;
        check({tag, "_lvl"}, lv, exp_lvl);
        do begin
            @(negedge clk);
            n++;
            if (phase_done && clk_out == lv) spurious++;
        end while (clk_out == lv && n < 64);
        check({tag, "_len"}, n, exp_n);
        check({tag, "_pd"}, phase_done, 1);
    endtask

    // Button press lasting one cycle; mode must change one edge later.
    task automatic press(input string tag, input logic up, input logic dn,
                         input int old_mode, input int new_mode);
        speed_up   = up;
        speed_down = dn;
        @(negedge clk);
        speed_up   = 1'b0;
        speed_down = 1'b0;
        check({tag, "_early"}, mode, old_mode);
        @(negedge clk);
        check({tag, "_mode"}, mode, new_mode);
        check({tag, "_pd0"}, phase_done, 0);
    endtask

    initial begin
        int         toggles;
        logic [8:0] obs1;
        logic [8:0] obs2;

        reset      = 1'b1;
        speed_up   = 1'b0;
        speed_down = 1'b0;
        hold       = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_clk_out", clk_out, 0);
        check("rst_mode", mode, 0);
        check("rst_pd", phase_done, 0);
        reset = 1'b0;

        // 1: mode 0 runs 3 low / 6 high
        measure("m0_low_a", 1'b0, 3);
        measure("m0_high_a", 1'b1, 6);
        measure("m0_low_b", 1'b0, 3);
        measure("m0_high_b", 1'b1, 6);
        check("m0_mode", mode, 0);

        // 2: step up to 1, then wrap 2 -> 0
        press("up_0to1", 1'b1, 1'b0, 0, 1);
        measure("m1_low", 1'b0, 2);
        measure("m1_high", 1'b1, 4);
        press("up_1to2", 1'b1, 1'b0, 1, 2);
        press("up_2to0", 1'b1, 1'b0, 2, 0);
        measure("wrap_m0_high", 1'b1, 6);

        // 3: down wraps 0 -> 2; simultaneous press does nothing
        press("dn_0to2", 1'b0, 1'b1, 0, 2);
        measure("m2_low", 1'b0, 1);
        measure("m2_high", 1'b1, 2);
        speed_up   = 1'b1;
        speed_down = 1'b1;
        @(negedge clk);
        speed_up   = 1'b0;
        speed_down = 1'b0;
        @(negedge clk);
        check("both_mode", mode, 2);
        measure("both_rest_high", 1'b1, 1);
        measure("both_low", 1'b0, 1);

        // 4: step in the terminal-count cycle of a mode-0 high phase
        press("up_2to0_b", 1'b1, 1'b0, 2, 0);
        repeat (4) @(negedge clk);
        speed_up = 1'b1;
        @(negedge clk);
        speed_up = 1'b0;
        @(negedge clk);
        check("tcstep_lvl", clk_out, 1);
        check("tcstep_pd", phase_done, 0);
        check("tcstep_mode", mode, 1);
        measure("tcstep_m1_high", 1'b1, 4);

        // 5: hold for 10 cycles one cycle into a mode-1 high phase
        measure("hold_pre_low", 1'b0, 2);
        @(negedge clk);
        hold    = 1'b1;
        toggles = 0;
        repeat (10) begin
            @(negedge clk);
            if (clk_out !== 1'b1 || phase_done !== 1'b0) toggles++;
        end
        check("hold_frozen", toggles, 0);
        hold = 1'b0;
        measure("hold_rest_high", 1'b1, 3);

        // 6: reset mid-phase in mode 2 with speed_up held across it
        press("up_1to2_b", 1'b1, 1'b0, 1, 2);
        @(negedge clk);
        check("pre_rst_lvl", clk_out, 1);
        reset    = 1'b1;
        speed_up = 1'b1;
        @(negedge clk);
        check("mid_rst_clk_out", clk_out, 0);
        check("mid_rst_mode", mode, 0);
        check("mid_rst_pd", phase_done, 0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            obs1[i] = clk_out;
            obs2[i] = clk_out2;
        end
        check("post_rst_wave", obs1, 9'b0_1111_1100);
        check("post_rst_mode", mode, 0);
        check("zero_low_wave", obs2, 9'b1_1011_1111);
        check("zero_low_mode", mode2, 0);
        speed_up = 1'b0;

        check("pd_spurious", spurious, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_blink_rate_gen
`default_nettype wire
